// File: rtl/spi_master_xfer.sv
// SPI mode-0 initiator: one control byte then len payload bytes per start,
// full-duplex and MSB first, with every output driven from a register.
module spi_master_xfer #(
    parameter int HALF = 4,
    parameter int LW   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [7:0]    cmd,
    input  logic [LW-1:0] len,
    input  logic [7:0]    tx_data,
    output logic          tx_req,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    output logic [7:0]    dev_id,
    output logic          busy,
    output logic          done,
    output logic          ncs,
    output logic          sck,
    output logic          mosi,
    input  logic          miso
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, DESEL} state_t;

    localparam logic [7:0] HLAST = 8'(HALF - 1);

    state_t        state, state_nx;
    logic [7:0]    hcnt, hcnt_nx;
    logic [2:0]    bcnt, bcnt_nx;
    logic [LW:0]   byte_cnt, byte_cnt_nx;
    logic [LW-1:0] len_q, len_nx;
    logic [7:0]    tsr, tsr_nx;
    logic [7:0]    rsr, rsr_nx;
    logic          tx_req_nx, rx_valid_nx, busy_nx, done_nx;
    logic          ncs_nx, sck_nx, mosi_nx;
    logic [7:0]    rx_data_nx, dev_id_nx;
    logic          hend;

    assign hend = (hcnt == HLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hcnt     <= '0;
            bcnt     <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            tsr      <= '0;
            rsr      <= '0;
            tx_req   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            dev_id   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ncs      <= 1'b1;
            sck      <= 1'b0;
            mosi     <= 1'b0;
        end else begin
            state    <= state_nx;
            hcnt     <= hcnt_nx;
            bcnt     <= bcnt_nx;
            byte_cnt <= byte_cnt_nx;
            len_q    <= len_nx;
            tsr      <= tsr_nx;
            rsr      <= rsr_nx;
            tx_req   <= tx_req_nx;
            rx_valid <= rx_valid_nx;
            rx_data  <= rx_data_nx;
            dev_id   <= dev_id_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            ncs      <= ncs_nx;
            sck      <= sck_nx;
            mosi     <= mosi_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        hcnt_nx     = hcnt;
        bcnt_nx     = bcnt;
        byte_cnt_nx = byte_cnt;
        len_nx      = len_q;
        tsr_nx      = tsr;
        rsr_nx      = rsr;
        tx_req_nx   = 1'b0;
        rx_valid_nx = 1'b0;
        rx_data_nx  = rx_data;
        dev_id_nx   = dev_id;
        busy_nx     = busy;
        done_nx     = 1'b0;
        ncs_nx      = ncs;
        sck_nx      = sck;
        mosi_nx     = mosi;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx    = SHIFT;
                    hcnt_nx     = '0;
                    bcnt_nx     = '0;
                    byte_cnt_nx = '0;
                    len_nx      = len;
                    tsr_nx      = cmd;
                    busy_nx     = 1'b1;
                    ncs_nx      = 1'b0;
                    sck_nx      = 1'b0;
                    mosi_nx     = cmd[7];
                end
            end
            SHIFT: begin
                hcnt_nx = hcnt + 8'd1;
                // tx_req was raised on the byte boundary; take the byte now
                if (tx_req) begin
                    tsr_nx  = tx_data;
                    mosi_nx = tx_data[7];
                end
                if (hend) begin
                    hcnt_nx = '0;
                    if (!sck) begin
                        sck_nx = 1'b1;
                        rsr_nx = {rsr[6:0], miso};
                    end else begin
                        sck_nx = 1'b0;
                        if (bcnt != 3'd7) begin
                            bcnt_nx = bcnt + 3'd1;
                            tsr_nx  = {tsr[6:0], 1'b0};
                            mosi_nx = tsr[6];
                        end else begin
                            bcnt_nx = '0;
                            if (byte_cnt == '0) begin
                                dev_id_nx = rsr;
                            end else begin
                                rx_data_nx  = rsr;
                                rx_valid_nx = 1'b1;
                            end
                            if (byte_cnt == {1'b0, len_q}) begin
                                state_nx = HOLD;
                            end else begin
                                byte_cnt_nx = byte_cnt + (LW+1)'(1);
                                tx_req_nx   = 1'b1;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                hcnt_nx = hcnt + 8'd1;
                if (hend) begin
                    hcnt_nx  = '0;
                    state_nx = DESEL;
                    ncs_nx   = 1'b1;
                    mosi_nx  = 1'b0;
                end
            end
            DESEL: begin
                hcnt_nx = hcnt + 8'd1;
                if (hend) begin
                    hcnt_nx  = '0;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Directed bench for spi_master_xfer: a HALF=4 instance with a byte-stream
// target model and a HALF=7 instance wired in loopback.
module tb_spi_master_xfer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, tx_req, rx_valid, busy, done, ncs, sck, mosi, miso;
    logic [7:0]  cmd, tx_data, rx_data, dev_id;
    logic [15:0] len;

    logic        start_b, tx_req_b, rx_valid_b, busy_b, done_b;
    logic        ncs_b, sck_b, mosi_b;
    logic [7:0]  cmd_b, tx_data_b, rx_data_b, dev_id_b;
    logic [15:0] len_b;

    spi_master_xfer #(.HALF(4), .LW(16)) dut (
        .clk(clk), .rst(rst), .start(start), .cmd(cmd), .len(len),
        .tx_data(tx_data), .tx_req(tx_req), .rx_data(rx_data),
        .rx_valid(rx_valid), .dev_id(dev_id), .busy(busy), .done(done),
        .ncs(ncs), .sck(sck), .mosi(mosi), .miso(miso)
    );

    spi_master_xfer #(.HALF(7), .LW(16)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .cmd(cmd_b), .len(len_b),
        .tx_data(tx_data_b), .tx_req(tx_req_b), .rx_data(rx_data_b),
        .rx_valid(rx_valid_b), .dev_id(dev_id_b), .busy(busy_b),
        .done(done_b), .ncs(ncs_b), .sck(sck_b), .mosi(mosi_b),
        .miso(mosi_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // target model: byte sl[k] bit (7-i) is presented before rise 8k+i
    logic [7:0]  sl [8];
    logic [7:0]  txq [8];
    logic        tie_hi = 1'b0;
    logic        mbit = 1'b0;
    int          srises = 0;
    assign miso = tie_hi ? 1'b1 : mbit;

    int          cyc = 0, rises = 0, busy_n = 0, done_n = 0, ncs_low_n = 0;
    int          txr_n = 0, rx_n = 0, txi = 0, desel_n = 0;
    int          txr_t [8];
    logic [7:0]  rxq [8];
    logic [63:0] mosi_sr = '0;
    logic        prev_sck = 1'b0;

    always @(negedge clk) begin
        if (sck && !prev_sck) begin
            rises++;
            srises++;
            mosi_sr = {mosi_sr[62:0], mosi};
        end
        if (ncs) srises = 0;
        mbit = sl[(srises / 8) % 8][7 - (srises % 8)];
        if (busy) busy_n++;
        if (busy && ncs) desel_n++;
        if (!ncs) ncs_low_n++;
        if (done) done_n++;
        if (tx_req) begin
            txr_t[txr_n % 8] = cyc;
            txr_n++;
            tx_data = txq[txi % 8];
            txi++;
        end
        if (rx_valid) begin
            rxq[rx_n % 8] = rx_data;
            rx_n++;
        end
        prev_sck = sck;
        cyc++;
    end

    int          b_done_n = 0, b_rx_n = 0, b_txi = 0, b_run = 0;
    int          hi_min = 999, hi_max = 0, lo_min = 999, lo_max = 0;
    logic [7:0]  b_rxq [4];
    logic [7:0]  b_txq [4];
    logic        b_prev = 1'b0;

    always @(negedge clk) begin
        if (ncs_b) begin
            b_run = 0;
        end else if (sck_b != b_prev) begin
            if (sck_b) begin
                if (b_run < lo_min) lo_min = b_run;
                if (b_run > lo_max) lo_max = b_run;
            end else begin
                if (b_run < hi_min) hi_min = b_run;
                if (b_run > hi_max) hi_max = b_run;
            end
            b_run = 1;
        end else begin
            b_run++;
        end
        b_prev = sck_b;
        if (done_b) b_done_n++;
        if (rx_valid_b) begin
            b_rxq[b_rx_n % 4] = rx_data_b;
            b_rx_n++;
        end
        if (tx_req_b) begin
            tx_data_b = b_txq[b_txi % 4];
            b_txi++;
        end
    end

    task automatic clear_stats();
        rises = 0; busy_n = 0; done_n = 0; ncs_low_n = 0; desel_n = 0;
        txr_n = 0; rx_n = 0; txi = 0; mosi_sr = '0;
    endtask

    task automatic go(input logic [7:0] c, input logic [15:0] l);
        start = 1'b1; cmd = c; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int want);
        for (int i = 0; i < 4000 && done_n < want; i++) @(posedge clk);
        check(tag, 64'(done_n >= want), 64'd1);
        repeat (10) @(posedge clk);
        #1;
    endtask

    int          r;
    logic [63:0] mask, msnap;
    int          tsnap;

    initial begin
        rst = 1'b1; start = 1'b0; cmd = '0; len = '0; tx_data = '0;
        start_b = 1'b0; cmd_b = '0; len_b = '0; tx_data_b = '0;
        sl[0] = 8'h91; sl[1] = 8'h00; sl[2] = 8'h0A; sl[3] = 8'hBC;
        sl[4] = 8'h55; sl[5] = 8'h66; sl[6] = 8'h77; sl[7] = 8'h88;
        txq[0] = 8'h12; txq[1] = 8'h34; txq[2] = 8'h56; txq[3] = 8'h78;
        txq[4] = 8'h00; txq[5] = 8'h00; txq[6] = 8'h00; txq[7] = 8'h00;
        b_txq[0] = 8'hA5; b_txq[1] = 8'h3C; b_txq[2] = 8'h00;
        b_txq[3] = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ncs", 64'(ncs), 64'd1);
        check("rst_sck", 64'(sck), 64'd0);
        check("rst_mosi", 64'(mosi), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_flags", 64'({done, tx_req, rx_valid}), 64'd0);
        check("rst_rx_data", 64'(rx_data), 64'd0);
        check("rst_dev_id", 64'(dev_id), 64'd0);

        // write: cmd 0x80, four payload bytes
        clear_stats();
        go(8'h80, 16'd4);
        wait_done("wr_timeout", 1);
        check("wr_mosi", mosi_sr & 64'hFF_FFFF_FFFF, 64'h80_1234_5678);
        check("wr_dev_id", 64'(dev_id), 64'h91);
        check("wr_txreq_n", 64'(txr_n), 64'd4);
        check("wr_gap1", 64'(txr_t[1] - txr_t[0]), 64'd64);
        check("wr_gap2", 64'(txr_t[2] - txr_t[1]), 64'd64);
        check("wr_gap3", 64'(txr_t[3] - txr_t[2]), 64'd64);
        check("wr_busy", 64'(busy_n), 64'd328);
        check("wr_done_n", 64'(done_n), 64'd1);
        check("wr_ncs_low", 64'(ncs_low_n), 64'd324);
        check("wr_rises", 64'(rises), 64'd40);

        // read: cmd 0x01, three payload bytes
        clear_stats();
        go(8'h01, 16'd3);
        wait_done("rd_timeout", 1);
        check("rd_dev_id", 64'(dev_id), 64'h91);
        check("rd_rx_n", 64'(rx_n), 64'd3);
        check("rd_rx0", 64'(rxq[0]), 64'h00);
        check("rd_rx1", 64'(rxq[1]), 64'h0A);
        check("rd_rx2", 64'(rxq[2]), 64'hBC);
        check("rd_rises", 64'(rises), 64'd32);

        // command only, miso tied high
        clear_stats();
        tie_hi = 1'b1;
        go(8'h02, 16'd0);
        wait_done("l0_timeout", 1);
        tie_hi = 1'b0;
        check("l0_dev_id", 64'(dev_id), 64'hFF);
        check("l0_txreq_n", 64'(txr_n), 64'd0);
        check("l0_rx_n", 64'(rx_n), 64'd0);
        check("l0_busy", 64'(busy_n), 64'd72);
        check("l0_rises", 64'(rises), 64'd8);

        // loopback on the HALF=7 instance
        start_b = 1'b1; cmd_b = 8'h5A; len_b = 16'd2;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < 4000 && b_done_n == 0; i++) @(posedge clk);
        #1;
        check("lb_done", 64'(b_done_n), 64'd1);
        check("lb_dev_id", 64'(dev_id_b), 64'h5A);
        check("lb_rx_n", 64'(b_rx_n), 64'd2);
        check("lb_rx0", 64'(b_rxq[0]), 64'hA5);
        check("lb_rx1", 64'(b_rxq[1]), 64'h3C);
        check("lb_hi_phase", 64'({hi_min[15:0], hi_max[15:0]}),
              64'h0007_0007);
        check("lb_lo_phase", 64'({lo_min[15:0], lo_max[15:0]}),
              64'h0007_0007);

        // second start mid-transaction, then reset
        clear_stats();
        go(8'h80, 16'd4);
        for (int i = 0; i < 200 && busy_n < 50; i++) @(posedge clk);
        #1 start = 1'b1; cmd = 8'h03; len = 16'd1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 200 && busy_n < 100; i++) @(posedge clk);
        #1;
        r = rises;
        msnap = mosi_sr;
        tsnap = txr_n;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mask = (64'd1 << r) - 64'd1;
        check("ab_mosi", msnap & mask, 64'h80_1234_5678 >> (40 - r));
        check("ab_txreq_n", 64'(tsnap), 64'd1);
        check("ab_ncs", 64'(ncs), 64'd1);
        check("ab_sck", 64'(sck), 64'd0);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_dev_id", 64'(dev_id), 64'd0);
        @(posedge clk); #1;
        check("ab_no_done", 64'(done_n), 64'd0);
        clear_stats();
        go(8'h81, 16'd1);
        wait_done("ar_timeout", 1);
        check("ar_mosi", mosi_sr & 64'hFFFF, 64'h8112);
        check("ar_dev_id", 64'(dev_id), 64'h91);
        check("ar_busy", 64'(busy_n), 64'd136);

        // back-to-back: start in the done cycle
        clear_stats();
        go(8'h02, 16'd0);
        for (int i = 0; i < 4000 && !done; i++) @(negedge clk);
        start = 1'b1; cmd = 8'h81; len = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check("bb_busy", 64'(busy), 64'd1);
        check("bb_ncs", 64'(ncs), 64'd0);
        check("bb_desel", 64'(desel_n), 64'd4);
        wait_done("bb_timeout", 2);
        check("bb_done_n", 64'(done_n), 64'd2);
        check("bb_busy_tot", 64'(busy_n), 64'd208);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
